// File: rtl/divisor_restador.sv
// -----------------------------------------------------------------------------
// divisor_restador
//
// Sequential unsigned restoring divider. One W-bit trial subtraction per clock
// produces one quotient bit, so a division takes W iterations. Operands are
// taken through a start/busy/done handshake. The quotient, remainder and
// divide-by-zero flag are held until the next accepted operation completes.
//
// Optional feature: define DIVISOR_RESTADOR_DIV0_EN to short-circuit a zero
// divisor (one cycle in CALC instead of W) and report it on div0. Without the
// macro, div0 is tied low and b=0 runs the normal W-cycle algorithm, which
// naturally yields cociente=all ones and residuo=a.
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   asynchronous, active-high reset
//   start     in   request; sampled only when busy=0 (IDLE or DONE)
//   a         in   W-bit unsigned dividend, sampled with start
//   b         in   W-bit unsigned divisor, sampled with start
//   busy      out  high while iterating
//   done      out  one-cycle pulse, results valid
//   cociente  out  W-bit quotient, held until the next result
//   residuo   out  W-bit remainder, held until the next result
//   div0      out  divisor was zero (only with DIVISOR_RESTADOR_DIV0_EN)
// -----------------------------------------------------------------------------
module divisor_restador #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] cociente,
    output logic [W-1:0] residuo,
    output logic         div0
);

    localparam int NW = $clog2(W);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [NW-1:0] N_LAST = NW'(W - 1);

    logic [1:0]    r_state;
    logic [W-1:0]  r_q;          // dividend shifting out, quotient shifting in
    logic [W-1:0]  r_d;          // latched divisor
    // The algorithm's partial remainder is W+1 bits, but only its low W bits
    // are ever shifted back in, so the top bit is never stored.
    logic [W-1:0]  r_r;
    logic [NW-1:0] r_n;
    logic [W-1:0]  r_cociente;
    logic [W-1:0]  r_residuo;

    logic [W:0]    w_shift;
    logic [W:0]    w_diff;
    logic          w_borrow;
    logic [W-1:0]  w_r_next;
    logic [W-1:0]  w_q_next;
    logic          w_last;

    // One restoring step: shift the next dividend bit into the remainder and
    // try subtracting the divisor; keep the difference only if it did not
    // borrow.
    always_comb begin
        // NOTE: every always_comb output is assigned on every path, so no
        // latch can be inferred.
        w_shift  = {r_r, r_q[W-1]};
        w_diff   = w_shift - {1'b0, r_d};
        w_borrow = w_diff[W];
        w_r_next = w_borrow ? w_shift[W-1:0] : w_diff[W-1:0];
        w_q_next = {r_q[W-2:0], ~w_borrow};
        w_last   = (r_n == N_LAST);
    end

`ifdef DIVISOR_RESTADOR_DIV0_EN
    logic r_div0;
`endif

    // NOTE: all state here is registered with non-blocking assignments so
    // every register samples the values from before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: every register, datapath included, is cleared so a reset
            // mid-operation leaves no stale operands or results behind.
            r_state    <= S_IDLE;
            r_q        <= '0;
            r_d        <= '0;
            r_r        <= '0;
            r_n        <= '0;
            r_cociente <= '0;
            r_residuo  <= '0;
`ifdef DIVISOR_RESTADOR_DIV0_EN
            r_div0     <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_CALC: begin
`ifdef DIVISOR_RESTADOR_DIV0_EN
                    // Zero divisor: report the algorithm's natural result
                    // straight away instead of iterating.
                    if (r_d == '0) begin
                        r_state    <= S_DONE;
                        r_cociente <= '1;
                        r_residuo  <= r_q;
                        r_div0     <= 1'b1;
                    end else
`endif
                    begin
                        r_r <= w_r_next;
                        r_q <= w_q_next;
                        r_n <= r_n + NW'(1);
                        // Results are published only on the final step, so
                        // partial values never reach the outputs.
                        if (w_last) begin
                            r_state    <= S_DONE;
                            r_cociente <= w_q_next;
                            r_residuo  <= w_r_next;
`ifdef DIVISOR_RESTADOR_DIV0_EN
                            r_div0     <= 1'b0;
`endif
                        end
                    end
                end

                // IDLE and DONE both accept a new request; DONE therefore
                // supports back-to-back operation.
                default: begin
                    if (start) begin
                        r_state <= S_CALC;
                        r_q     <= a;
                        r_d     <= b;
                        r_r     <= '0;
                        r_n     <= '0;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy     = (r_state == S_CALC);
    assign done     = (r_state == S_DONE);
    assign cociente = r_cociente;
    assign residuo  = r_residuo;

`ifdef DIVISOR_RESTADOR_DIV0_EN
    assign div0 = r_div0;
`else
    assign div0 = 1'b0;
`endif

endmodule

// File: tb/tb_divisor_restador.sv
// -----------------------------------------------------------------------------
// tb_divisor_restador
//
// Self-checking bench for divisor_restador (W=8). Expected results come from
// plain integer division in the bench; latency and handshake expectations
// come from the documented cycle timing.
// -----------------------------------------------------------------------------
module tb_divisor_restador;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] cociente;
    logic [W-1:0] residuo;
    logic         div0;

    int total;
    int bad;
    int done_cnt;

    // Last result the outputs should be holding.
    logic [W-1:0] prev_q;
    logic [W-1:0] prev_r;

    divisor_restador #(.W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .cociente (cociente),
        .residuo  (residuo),
        .div0     (div0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count done pulses away from the active edge.
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: unsigned division, zero divisor gives all ones / a.
    task automatic ref_div(input logic [W-1:0] ta, input logic [W-1:0] tb,
                           output logic [W-1:0] eq, output logic [W-1:0] er,
                           output logic ed0, output int lat);
        int ia;
        int ib;
        ia = int'(ta);
        ib = int'(tb);
        if (ib == 0) begin
            eq = {W{1'b1}};
            er = ta;
        end else begin
            eq = W'(ia / ib);
            er = W'(ia % ib);
        end
`ifdef DIVISOR_RESTADOR_DIV0_EN
        ed0 = (ib == 0);
        lat = (ib == 0) ? 1 : W;
`else
        ed0 = 1'b0;
        lat = W;
`endif
    endtask

    // One complete operation: accept, iterate, check the done cycle.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input string name);
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         ed0;
        int           exp_lat;
        int           lat;
        bit           busy_ok;
        bit           hold_ok;
        ref_div(ta, tb, eq, er, ed0, exp_lat);
        start = 1'b1;
        a     = ta;
        b     = tb;
        tick();
        start = 1'b0;
        // Scramble operands: they must not be re-sampled.
        a     = W'($urandom);
        b     = W'($urandom);
        lat     = 0;
        busy_ok = 1'b1;
        hold_ok = 1'b1;
        while (done !== 1'b1 && lat < 40) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (cociente !== prev_q || residuo !== prev_r) hold_ok = 1'b0;
            tick();
            lat++;
        end
        total++;
        if (lat !== exp_lat) begin
            bad++;
            $display("FAIL %s latency: got=%0d exp=%0d", name, lat, exp_lat);
        end
        total++;
        if (busy_ok !== 1'b1) begin
            bad++;
            $display("FAIL %s busy during calc: got=%0d exp=1", name, busy_ok);
        end
        total++;
        if (hold_ok !== 1'b1) begin
            bad++;
            $display("FAIL %s outputs held during calc: got=%0d exp=1", name, hold_ok);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL %s busy in done cycle: got=%0b exp=0", name, busy);
        end
        total++;
        if (cociente !== eq) begin
            bad++;
            $display("FAIL %s cociente: a=%0d b=%0d got=%0d exp=%0d", name, ta, tb, cociente, eq);
        end
        total++;
        if (residuo !== er) begin
            bad++;
            $display("FAIL %s residuo: a=%0d b=%0d got=%0d exp=%0d", name, ta, tb, residuo, er);
        end
        total++;
        if (div0 !== ed0) begin
            bad++;
            $display("FAIL %s div0: got=%0b exp=%0b", name, div0, ed0);
        end
        tick();
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL %s done pulse width: got=%0b exp=0", name, done);
        end
        prev_q = eq;
        prev_r = er;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) tick();
        total++;
        if ({busy, done, div0, cociente, residuo} !== '0) begin
            bad++;
            $display("FAIL reset outputs: got=%0h exp=0", {busy, done, div0, cociente, residuo});
        end
        rst = 1'b0;
        tick();
        total++;
        if ({busy, done} !== 2'b00) begin
            bad++;
            $display("FAIL idle after reset busy/done: got=%0b exp=0", {busy, done});
        end
        prev_q = '0;
        prev_r = '0;
    endtask

    task automatic test_directed();
        int cnt0;
        cnt0 = done_cnt;
        do_op(8'd100, 8'd7, "100/7");
        repeat (3) tick();
        total++;
        if (done_cnt - cnt0 !== 1) begin
            bad++;
            $display("FAIL 100/7 done pulses: got=%0d exp=1", done_cnt - cnt0);
        end
        do_op(8'd255, 8'd1, "255/1");
        do_op(8'd5,   8'd9, "5/9");
        do_op(8'd0,   8'd3, "0/3");
    endtask

    task automatic test_div0();
        do_op(8'h3C, 8'h00, "div0");
    endtask

    task automatic test_back_to_back();
        int lat;
        int cnt0;
        cnt0  = done_cnt;
        start = 1'b1;
        a     = 8'd200;
        b     = 8'd3;
        tick();
        start = 1'b0;
        lat   = 0;
        tick(); lat++;
        tick(); lat++;
        // Request while busy: must be ignored.
        start = 1'b1;
        a     = 8'd9;
        b     = 8'd9;
        tick(); lat++;
        start = 1'b0;
        tick(); lat++;
        // Hold start from here through the DONE cycle.
        start = 1'b1;
        while (done !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        total++;
        if (lat !== W) begin
            bad++;
            $display("FAIL b2b first latency: got=%0d exp=%0d", lat, W);
        end
        total++;
        if (cociente !== 8'd66 || residuo !== 8'd2) begin
            bad++;
            $display("FAIL b2b first result: got=%0d/%0d exp=66/2", cociente, residuo);
        end
        tick();
        start = 1'b0;
        total++;
        if ({busy, done} !== 2'b10) begin
            bad++;
            $display("FAIL b2b accept busy/done: got=%0b exp=10", {busy, done});
        end
        total++;
        if (cociente !== 8'd66 || residuo !== 8'd2) begin
            bad++;
            $display("FAIL b2b result held: got=%0d/%0d exp=66/2", cociente, residuo);
        end
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        total++;
        if (lat !== W) begin
            bad++;
            $display("FAIL b2b second latency: got=%0d exp=%0d", lat, W);
        end
        total++;
        if (cociente !== 8'd1 || residuo !== 8'd0) begin
            bad++;
            $display("FAIL b2b second result: got=%0d/%0d exp=1/0", cociente, residuo);
        end
        tick();
        total++;
        if (done_cnt - cnt0 !== 2) begin
            bad++;
            $display("FAIL b2b done pulses: got=%0d exp=2", done_cnt - cnt0);
        end
        prev_q = 8'd1;
        prev_r = 8'd0;
    endtask

    task automatic test_reset_mid();
        int cnt0;
        start = 1'b1;
        a     = 8'd77;
        b     = 8'd5;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        #1;
        total++;
        if ({busy, done, div0, cociente, residuo} !== '0) begin
            bad++;
            $display("FAIL mid reset outputs: got=%0h exp=0", {busy, done, div0, cociente, residuo});
        end
        cnt0 = done_cnt;
        tick();
        rst = 1'b0;
        repeat (12) tick();
        total++;
        if (done_cnt !== cnt0) begin
            bad++;
            $display("FAIL mid reset done pulses: got=%0d exp=0", done_cnt - cnt0);
        end
        total++;
        if ({busy, cociente, residuo} !== '0) begin
            bad++;
            $display("FAIL after mid reset outputs: got=%0h exp=0", {busy, cociente, residuo});
        end
        prev_q = '0;
        prev_r = '0;
        do_op(8'd50, 8'd6, "50/6 after reset");
    endtask

    task automatic test_random();
        int cnt0;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        cnt0 = done_cnt;
        for (int i = 0; i < 100; i++) begin
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(1, 255));
            do_op(ra, rb, "random");
        end
        total++;
        if (done_cnt - cnt0 !== 100) begin
            bad++;
            $display("FAIL random done count: got=%0d exp=100", done_cnt - cnt0);
        end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        done_cnt = 0;
        test_reset();
        test_directed();
        test_div0();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
